// File: rtl/alu_mul_seq_pkg.sv
// Shared control-word constants and the multiply sequencer's state encoding.
// Imported by the multiply sequencer, its interface and its bench.
package alu_mul_seq_pkg;

    localparam int ALU_OP_WIDTH = 4;

    localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD = 4'd0;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB = 4'd1;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_AND = 4'd2;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OR  = 4'd3;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR = 4'd4;

    localparam int MUL_WIDTH     = 8;
    localparam int MUL_CNT_WIDTH = $clog2(MUL_WIDTH) + 1;

    typedef enum logic [1:0] {
        MUL_IDLE  = 2'd0,
        MUL_ADD   = 2'd1,
        MUL_SHIFT = 2'd2,
        MUL_DONE  = 2'd3
    } mul_state_e;

endpackage

// File: rtl/alu_mul_seq_if.sv
// Request/result handshake between the issuing logic and the multiplier.
// master drives start and operands; slave returns busy/done/product.
interface alu_mul_seq_if #(
    parameter int WIDTH = 8
);

    logic               i_start;
    logic [WIDTH-1:0]   i_mcand;
    logic [WIDTH-1:0]   i_mplier;
    logic               o_busy;
    logic               o_done;
    logic [2*WIDTH-1:0] o_product;

    modport master (
        output i_start,
        output i_mcand,
        output i_mplier,
        input  o_busy,
        input  o_done,
        input  o_product
    );

    modport slave (
        input  i_start,
        input  i_mcand,
        input  i_mplier,
        output o_busy,
        output o_done,
        output o_product
    );

endinterface

// File: rtl/alu_mul_seq.sv
// Unsigned shift-and-add multiplier that borrows the shared ALU's ADD
// and latched carry; one ADD plus one SHIFT step per multiplier bit.
module alu_mul_seq
    import alu_mul_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    i_rst_n,
    input  logic                    clk_en,
    alu_mul_seq_if.slave            bus,
    output logic                    o_alu_own,
    output logic [ALU_OP_WIDTH-1:0] o_alu_op,
    output logic [WIDTH-1:0]        o_alu_a,
    output logic [WIDTH-1:0]        o_alu_t,
    output logic                    o_alu_latch_flags,
    input  logic [WIDTH-1:0]        i_alu_data,
    input  logic                    i_alu_carry
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    mul_state_e         r_state;
    mul_state_e         w_next_state;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_acc_hi;
    logic [WIDTH-1:0]   r_acc_lo;
    logic [CNT_W-1:0]   r_count;
    logic [2*WIDTH-1:0] r_product;

    logic [WIDTH-1:0]   w_shift_hi;
    logic [WIDTH-1:0]   w_shift_lo;
    logic               w_last;
    logic               w_in_add;
    logic               w_in_shift;

    assign w_in_add   = (r_state == MUL_ADD);
    assign w_in_shift = (r_state == MUL_SHIFT);

    // The carry out of the preceding ADD becomes the new top product bit.
    assign w_shift_hi = {i_alu_carry, r_acc_hi[WIDTH-1:1]};
    assign w_shift_lo = {r_acc_hi[0], r_acc_lo[WIDTH-1:1]};
    assign w_last     = (r_count == CNT_W'(WIDTH - 1));

    // State register; reset wins over clk_en so an abort is always possible.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_state <= MUL_IDLE;
        end else if (clk_en) begin
            r_state <= w_next_state;
        end
    end

    // Next-state: fixed ADD/SHIFT alternation, start honoured only in IDLE.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            MUL_IDLE: begin
                if (bus.i_start) begin
                    w_next_state = MUL_ADD;
                end
            end
            MUL_ADD: begin
                w_next_state = MUL_SHIFT;
            end
            MUL_SHIFT: begin
                w_next_state = w_last ? MUL_DONE : MUL_ADD;
            end
            MUL_DONE: begin
                w_next_state = MUL_IDLE;
            end
            default: begin
                w_next_state = MUL_IDLE;
            end
        endcase
    end

    // Operand capture, accumulator shift register, step count and result.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_mcand   <= '0;
            r_acc_hi  <= '0;
            r_acc_lo  <= '0;
            r_count   <= '0;
            r_product <= '0;
        end else if (clk_en) begin
            unique case (r_state)
                MUL_IDLE: begin
                    if (bus.i_start) begin
                        r_mcand  <= bus.i_mcand;
                        r_acc_lo <= bus.i_mplier;
                        r_acc_hi <= '0;
                        r_count  <= '0;
                    end
                end
                MUL_ADD: begin
                    r_acc_hi <= i_alu_data;
                end
                MUL_SHIFT: begin
                    r_acc_hi <= w_shift_hi;
                    r_acc_lo <= w_shift_lo;
                    r_count  <= r_count + CNT_W'(1);
                    if (w_last) begin
                        r_product <= {w_shift_hi, w_shift_lo};
                    end
                end
                MUL_DONE: begin
                    r_count <= r_count;
                end
                default: begin
                    r_count <= r_count;
                end
            endcase
        end
    end

    // ALU borrow: add either mcand or zero so every bit latches a fresh carry.
    always_comb begin
        o_alu_own         = w_in_add | w_in_shift;
        o_alu_op          = ALU_ADD;
        o_alu_a           = '0;
        o_alu_t           = '0;
        o_alu_latch_flags = 1'b0;
        if (w_in_add) begin
            o_alu_a           = r_acc_hi;
            o_alu_t           = r_acc_lo[0] ? r_mcand : '0;
            o_alu_latch_flags = 1'b1;
        end
    end

    assign bus.o_busy    = w_in_add | w_in_shift;
    assign bus.o_done    = (r_state == MUL_DONE);
    assign bus.o_product = r_product;

endmodule
